// File: rtl/mem_line_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_line_responder
// Description : Single-outstanding-request memory responder. It accepts a
//               256-bit line read or write, waits a fixed number of clock edges
//               and then completes it with a one-cycle ack_o pulse. Read data
//               is presented on data_o and held until the next read completes.
//
// Ports       : clk_i     - clock; all logic on the rising edge
//               rst_i     - synchronous active-high reset
//               addr_i    - byte address; bits [4:0] ignored, the line index
//                           is taken from the next log2(DEPTH) bits and any
//                           higher bits are ignored, so addresses wrap
//               data_i    - write line data
//               enable_i  - request valid, held until ack_o
//               write_i   - 1 = write line, 0 = read line
//               ack_o     - one-cycle completion pulse
//               data_o    - read line data, valid while ack_o = 1
//               rd_cnt_o  - completed reads  (MEM_LINE_RESPONDER_STATS_EN only)
//               wr_cnt_o  - completed writes (MEM_LINE_RESPONDER_STATS_EN only)
//
// Parameters  : LATENCY   - accepting edge to ack_o rise, counted as in the
//                           module description below (legal 2..63)
//               DEPTH     - number of 256-bit lines, power of two
//
// Options     : `define MEM_LINE_RESPONDER_STATS_EN adds the two 32-bit
//               completion counters and their output ports.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_line_responder #(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
`ifdef MEM_LINE_RESPONDER_STATS_EN
    output logic [31:0]  rd_cnt_o,
    output logic [31:0]  wr_cnt_o,
`endif
    output logic [255:0] data_o
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    // Counter value at which the WAIT state hands over to ACK.
    localparam logic [5:0]  CNT_LAST = 6'(LATENCY - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t             state_q;
    logic [5:0]         cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               wr_q;
    logic [255:0]       wdata_q;
    logic               ack_q;
    logic [255:0]       rdata_q;

    // Backing store, left un-reset so contents survive rst_i; testbenches
    // reach it hierarchically by this name.
    logic [255:0]       memory [DEPTH];

    logic [IDX_W-1:0]   idx_d;
    logic               w_done;
    logic               w_mem_we;
    logic               w_unused_addr;

    assign idx_d         = addr_i[IDX_W+4:5];
    assign w_unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

    // Edge on which the pending request completes (WAIT -> ACK).
    assign w_done   = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);
    // A reset on the completing edge abandons the request, so gate the write.
    assign w_mem_we = w_done && wr_q && !rst_i;

    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            memory[idx_q] <= wdata_q;
        end
    end

`ifdef MEM_LINE_RESPONDER_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
`ifdef MEM_LINE_RESPONDER_STATS_EN
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= 1'b0;
                    if (enable_i) begin
                        idx_q   <= idx_d;
                        wr_q    <= write_i;
                        wdata_q <= data_i;
                        cnt_q   <= 6'd0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (w_done) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                        if (!wr_q) begin
                            rdata_q <= memory[idx_q];
                        end
`ifdef MEM_LINE_RESPONDER_STATS_EN
                        if (wr_q) begin
                            wr_cnt_q <= wr_cnt_q + 32'd1;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + 32'd1;
                        end
`endif
                    end
                end
                ST_ACK: begin
                    // Unconditional return; enable_i seen here is ignored.
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;
`ifdef MEM_LINE_RESPONDER_STATS_EN
    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_line_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_line_responder
// Description : Directed self-checking bench for mem_line_responder with the
//               default LATENCY = 10 and DEPTH = 512. The request cycle is
//               counted as cycle 0, so a lone request sees ack_o in cycle 10.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_line_responder;

    logic         clk;
    logic         rst;
    logic [31:0]  addr;
    logic [255:0] din;
    logic         en;
    logic         wr;
    logic         ack;
    logic [255:0] dout;
`ifdef MEM_LINE_RESPONDER_STATS_EN
    logic [31:0]  rd_cnt;
    logic [31:0]  wr_cnt;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    localparam logic [255:0] C_PAT0 = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    localparam logic [255:0] C_PAT1 = {16{16'h5A5A}};
    localparam logic [255:0] C_PAT2 = {16{16'hECFA}};
    localparam logic [255:0] C_PAT32 = {16{16'hC00C}};
    localparam logic [255:0] C_A5   = {32{8'hA5}};

    mem_line_responder dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .addr_i   (addr),
        .data_i   (din),
        .enable_i (en),
        .write_i  (wr),
        .ack_o    (ack),
`ifdef MEM_LINE_RESPONDER_STATS_EN
        .rd_cnt_o (rd_cnt),
        .wr_cnt_o (wr_cnt),
`endif
        .data_o   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h required=%h", tag, obs, exp);
        end
    endtask

    // Issue one request; lat = rising edges from the drive point until ack_o
    // is seen (-1 on timeout). Unless keep is set, enable_i is dropped at the
    // ack and one more edge is taken to confirm the pulse lasted one cycle.
    task automatic do_req(input logic [31:0] a, input logic [255:0] d, input logic w,
                          input bit keep, output int lat, output logic [255:0] rdata);
        addr = a;
        din  = d;
        wr   = w;
        en   = 1'b1;
        lat  = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) begin
                lat = k;
                break;
            end
        end
        rdata = dout;
        if (!keep || lat < 0) begin
            en = 1'b0;
            @(posedge clk);
            #1;
            chk("ack_one_cycle", {255'd0, ack}, 256'd0);
        end
    endtask

    initial begin : main
        int           lat;
        int           acks;
        logic [255:0] rd;

        rst  = 1'b1;
        en   = 1'b0;
        wr   = 1'b0;
        addr = 32'd0;
        din  = '0;
        dut.memory[0]  = C_PAT0;
        dut.memory[1]  = C_PAT1;
        dut.memory[2]  = C_PAT2;
        dut.memory[17] = '0;
        dut.memory[32] = C_PAT32;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack", {255'd0, ack}, 256'd0);
        chk("reset_data", dout, 256'd0);
        rst = 1'b0;

        // Plain read of line 0: ack in cycle 10.
        do_req(32'h0000_0000, '0, 1'b0, 1'b0, lat, rd);
        chk("rd0_latency", 256'(lat), 256'd10);
        chk("rd0_data", rd, C_PAT0);
        chk("rd0_data_held", dout, C_PAT0);

        // Write 0x0220 then back-to-back read with enable kept high.
        do_req(32'h0000_0220, C_A5, 1'b1, 1'b1, lat, rd);
        chk("wr17_latency", 256'(lat), 256'd10);
        chk("wr17_mem", dut.memory[17], C_A5);
        chk("wr_keeps_data_o", rd, C_PAT0);
        do_req(32'h0000_0220, '0, 1'b0, 1'b0, lat, rd);
        chk("b2b_gap", 256'(lat), 256'd11);
        chk("rd17_data", rd, C_A5);

        // Offset bits ignored, and upper address bits wrap.
        do_req(32'h0000_0045, '0, 1'b0, 1'b0, lat, rd);
        chk("rd_offset_data", rd, C_PAT2);
        do_req(32'h0000_4020, '0, 1'b0, 1'b0, lat, rd);
        chk("rd_wrap_data", rd, C_PAT1);

        // Write to 0x0400 abandoned by a reset in cycle 5.
        addr = 32'h0000_0400;
        din  = {256{1'b1}};
        wr   = 1'b1;
        en   = 1'b1;
        acks = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) acks++;
        end
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) acks++;
        end
        rst = 1'b0;
        chk("rst_clears_data", dout, 256'd0);
        repeat (15) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) acks++;
        end
        chk("rst_no_ack", 256'(acks), 256'd0);
        chk("rst_mem32_kept", dut.memory[32], C_PAT32);

        // Inputs changed after acceptance must not affect the request.
        addr = 32'h0000_0000;
        wr   = 1'b0;
        din  = '0;
        en   = 1'b1;
        @(posedge clk);
        #1;
        addr = 32'h0000_0020;
        wr   = 1'b1;
        din  = {32{8'h3C}};
        lat  = -1;
        for (int k = 2; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) begin
                lat = k;
                break;
            end
        end
        en = 1'b0;
        chk("late_change_latency", 256'(lat), 256'd10);
        chk("late_change_data", dout, C_PAT0);
        chk("late_change_mem1", dut.memory[1], C_PAT1);
        @(posedge clk);
        #1;

`ifdef MEM_LINE_RESPONDER_STATS_EN
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_req(32'h0000_0000, '0, 1'b0, 1'b0, lat, rd);
        do_req(32'h0000_0060, {32{8'h11}}, 1'b1, 1'b0, lat, rd);
        do_req(32'h0000_0040, '0, 1'b0, 1'b0, lat, rd);
        do_req(32'h0000_0080, {32{8'h22}}, 1'b1, 1'b0, lat, rd);
        do_req(32'h0000_0060, '0, 1'b0, 1'b0, lat, rd);
        chk("stats_rd3_data", rd, {32{8'h11}});
        chk("stats_rd_cnt", 256'(rd_cnt), 256'd3);
        chk("stats_wr_cnt", 256'(wr_cnt), 256'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("stats_rd_cnt_rst", 256'(rd_cnt), 256'd0);
        chk("stats_wr_cnt_rst", 256'(wr_cnt), 256'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
